// File: rtl/dsp_mac.sv
// dsp_mac: pipelined multiply-accumulate with MUL/MAC/MSUB/CHAIN modes and a valid pipeline with stall.
// Optional saturating accumulate is enabled by defining DSP_MAC_SAT_EN; otherwise results wrap.
module dsp_mac #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic              clock0,
  input  logic              sclr0,
  input  logic              ena0,
  input  logic              in_valid,
  input  logic [W-1:0]      dataa_0,
  input  logic [W-1:0]      datab_0,
  input  logic              signa,
  input  logic              signb,
  input  logic [1:0]        op,
  input  logic [2*W-1:0]    chainin,
  output logic [2*W-1:0]    result,
  output logic              out_valid,
  output logic              ovf
);

  localparam int unsigned PW = 2 * W;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MAC   = 2'b01,
    OP_MSUB  = 2'b10,
    OP_CHAIN = 2'b11
  } op_e;

  // Input capture stage
  logic          in_v_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sa_q;
  logic          sb_q;
  op_e           op_q;
  logic [PW-1:0] ch_q;

  always_ff @(posedge clock0) begin
    if (sclr0) begin
      in_v_q <= 1'b0;
    end else if (ena0) begin
      in_v_q <= in_valid;
    end
  end

  always_ff @(posedge clock0) begin
    if (ena0) begin
      a_q  <= dataa_0;
      b_q  <= datab_0;
      sa_q <= signa;
      sb_q <= signb;
      op_q <= op_e'(op);
      ch_q <= chainin;
    end
  end

  // Extending straight to 2W bits keeps the low 2W product bits identical to the (W+1)x(W+1) product.
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod0;

  always_comb begin
    a_x   = {{W{sa_q & a_q[W-1]}}, a_q};
    b_x   = {{W{sb_q & b_q[W-1]}}, b_q};
    prod0 = a_x * b_x;
  end

  logic          fin_v;
  op_e           fin_op;
  logic          fin_sg;
  logic [PW-1:0] fin_ch;
  logic [PW-1:0] fin_p;

  generate
    if (STAGES == 1) begin : g_nopipe
      assign fin_v  = in_v_q;
      assign fin_op = op_q;
      assign fin_sg = sa_q | sb_q;
      assign fin_ch = ch_q;
      assign fin_p  = prod0;
    end else begin : g_pipe
      logic          pv  [1:STAGES-1];
      op_e           pop [1:STAGES-1];
      logic          psg [1:STAGES-1];
      logic [PW-1:0] pch [1:STAGES-1];
      logic [PW-1:0] pp  [1:STAGES-1];

      always_ff @(posedge clock0) begin
        if (sclr0) begin
          for (int unsigned i = 1; i < STAGES; i++) pv[i] <= 1'b0;
        end else if (ena0) begin
          pv[1] <= in_v_q;
          for (int unsigned i = 2; i < STAGES; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clock0) begin
        if (ena0) begin
          pop[1] <= op_q;
          psg[1] <= sa_q | sb_q;
          pch[1] <= ch_q;
          pp[1]  <= prod0;
          for (int unsigned i = 2; i < STAGES; i++) begin
            pop[i] <= pop[i-1];
            psg[i] <= psg[i-1];
            pch[i] <= pch[i-1];
            pp[i]  <= pp[i-1];
          end
        end
      end

      assign fin_v  = pv[STAGES-1];
      assign fin_op = pop[STAGES-1];
      assign fin_sg = psg[STAGES-1];
      assign fin_ch = pch[STAGES-1];
      assign fin_p  = pp[STAGES-1];
    end
  endgenerate

  // Accumulate stage; the extra top bit of add_x is the unsigned carry/borrow.
  logic [PW-1:0] base;
  logic [PW:0]   add_x;
  logic [PW-1:0] sum;
  logic          ov;
  logic [PW-1:0] nxt_res;
  logic          nxt_ovf;

  always_comb begin
    base = (fin_op == OP_CHAIN) ? fin_ch : result;
    if (fin_op == OP_MSUB) begin
      add_x = {1'b0, base} - {1'b0, fin_p};
    end else begin
      add_x = {1'b0, base} + {1'b0, fin_p};
    end
    sum = add_x[PW-1:0];
    if (fin_sg) begin
      if (fin_op == OP_MSUB) begin
        ov = (base[PW-1] != fin_p[PW-1]) && (sum[PW-1] != base[PW-1]);
      end else begin
        ov = (base[PW-1] == fin_p[PW-1]) && (sum[PW-1] != base[PW-1]);
      end
    end else begin
      ov = add_x[PW];
    end
    nxt_res = sum;
    nxt_ovf = ov;
`ifdef DSP_MAC_SAT_EN
    // Signed overflow direction always follows the sign of the accumulator-side operand.
    if (ov) begin
      if (fin_sg) begin
        nxt_res = base[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      end else begin
        nxt_res = (fin_op == OP_MSUB) ? '0 : '1;
      end
    end
`endif
    if (fin_op == OP_MUL) begin
      nxt_res = fin_p;
      nxt_ovf = 1'b0;
    end
  end

  always_ff @(posedge clock0) begin
    if (sclr0) begin
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena0) begin
      out_valid <= fin_v;
      if (fin_v) begin
        result <= nxt_res;
        ovf    <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac.sv
// Scoreboard bench for dsp_mac (W=32, STAGES=2): directed ops push expected results, a monitor checks retirements.
module tb_dsp_mac;

  logic        clock0 = 1'b0;
  logic        sclr0, ena0, in_valid, signa, signb;
  logic [31:0] dataa_0, datab_0;
  logic [1:0]  op;
  logic [63:0] chainin;
  logic [63:0] result;
  logic        out_valid, ovf;

`ifdef DSP_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  dsp_mac #(.W(32), .STAGES(2)) dut (
    .clock0(clock0), .sclr0(sclr0), .ena0(ena0), .in_valid(in_valid),
    .dataa_0(dataa_0), .datab_0(datab_0), .signa(signa), .signb(signb),
    .op(op), .chainin(chainin), .result(result), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clock0 = ~clock0;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  logic        ena_last = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clock0) begin
    cyc      <= cyc + 1;
    ena_last <= ena0 && !sclr0;
  end

  always @(negedge clock0) begin
    if (ena_last && out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got res=%h at cyc=%0d, want no retirement", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result !== e.res || ovf !== e.ov || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL retire: got res=%h ovf=%b cyc=%0d, want res=%h ovf=%b cyc=%0d",
                   result, ovf, cyc, e.res, e.ov, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic [63:0] ch, input bit push,
                       input logic [63:0] er, input logic eo, input int unsigned lat);
    op = o; dataa_0 = a; datab_0 = b; signa = sa; signb = sb; chainin = ch;
    in_valid = 1'b1;
    if (push) q.push_back('{er, eo, cyc + lat});
    @(negedge clock0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock0);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clock0);
  endtask

  initial begin
    int unsigned k;
    sclr0 = 1'b1; ena0 = 1'b1; in_valid = 1'b0; signa = 1'b0; signb = 1'b0;
    dataa_0 = '0; datab_0 = '0; op = 2'b00; chainin = '0;
    repeat (3) @(negedge clock0);
    sclr0 = 1'b0;
    chk("reset_result", result, 64'h0);
    chk("reset_ovf", {63'h0, ovf}, 64'h0);
    chk("reset_valid", {63'h0, out_valid}, 64'h0);

    // Full-range MUL, unsigned then signed
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'h0, 1, 64'hFFFFFFFE00000001, 0, 3);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 64'h0, 1, 64'h1, 0, 3);
    drain();

    // MUL, MAC, MSUB back-to-back
    issue(2'b00, 32'd3, 32'd4, 0, 0, 64'h0, 1, 64'd12, 0, 3);
    issue(2'b01, 32'd5, 32'd6, 0, 0, 64'h0, 1, 64'd42, 0, 3);
    issue(2'b10, 32'd2, 32'd2, 0, 0, 64'h0, 1, 64'd38, 0, 3);
    drain();

    // CHAIN with a bubble between ops
    k = cyc;
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 0, 1, 64'h10, 1, 64'h2, 0, 3);
    @(negedge clock0);
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 0, 1, 64'h10, 1, 64'h2, 0, 3);
    @(negedge clock0);
    chk("bubble_cycle", {31'h0, cyc}, {31'h0, k + 4});
    chk("bubble_valid", {63'h0, out_valid}, 64'h0);
    chk("bubble_hold", result, 64'h2);
    drain();

    // Signed overflow on MAC
    issue(2'b11, 32'd1, 32'd0, 1, 0, 64'h7FFFFFFFFFFFFFFF, 1, 64'h7FFFFFFFFFFFFFFF, 0, 3);
    issue(2'b01, 32'd1, 32'd1, 1, 1, 64'h0, 1,
          SAT ? 64'h7FFFFFFFFFFFFFFF : 64'h8000000000000000, 1, 3);
    drain();

    // Unsigned borrow on MSUB
    issue(2'b00, 32'd0, 32'd0, 0, 0, 64'h0, 1, 64'h0, 0, 3);
    issue(2'b10, 32'd1, 32'd1, 0, 0, 64'h0, 1, SAT ? 64'h0 : 64'hFFFFFFFFFFFFFFFF, 1, 3);
    drain();

    // Stall of 4 cycles one cycle after issue
    issue(2'b00, 32'd9, 32'd9, 0, 0, 64'h0, 1, 64'd81, 0, 7);
    ena0 = 1'b0;
    repeat (4) begin
      @(negedge clock0);
      chk("stall_valid", {63'h0, out_valid}, 64'h0);
    end
    ena0 = 1'b1;
    drain();

    // Reset with three MACs in flight
    issue(2'b01, 32'd1, 32'd1, 0, 0, 64'h0, 0, 64'h0, 0, 3);
    issue(2'b01, 32'd1, 32'd1, 0, 0, 64'h0, 0, 64'h0, 0, 3);
    op = 2'b01; dataa_0 = 32'd1; datab_0 = 32'd1; in_valid = 1'b1; sclr0 = 1'b1;
    @(negedge clock0);
    in_valid = 1'b0; sclr0 = 1'b0;
    repeat (3) begin
      chk("post_reset_result", result, 64'h0);
      chk("post_reset_valid", {63'h0, out_valid}, 64'h0);
      @(negedge clock0);
    end
    issue(2'b00, 32'd2, 32'd2, 0, 0, 64'h0, 1, 64'd4, 0, 3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_mac.md
# dsp_mac

Parametrised, pipelined multiply-accumulate unit; the next generation of the core's single-stage DSP multiplier. It adds configurable operand width and pipeline depth, a valid pipeline with stall, an internal accumulator with MUL/MAC/MSUB/CHAIN modes, and an optional saturating accumulate. It sits in the execute datapath wherever the multiplier is used today: long multiplies, MLA/MLS-style accumulates, and cascaded chains.

## Interface
Parameters:
- W, 32: operand width; product and accumulator are 2W bits.
- STAGES, 2: multiplier pipeline depth, ≥1.

Ports:
- clock0  in  1  clock; all state changes on its rising edge.
- sclr0  in  1  reset, synchronous and active-high.
- ena0  in  1  global clock enable; when low, every register holds.
- in_valid  in  1  operands and op valid this cycle.
- dataa_0  in  W  operand A.
- datab_0  in  W  operand B.
- signa  in  1  A is signed.
- signb  in  1  B is signed.
- op  in  2  00 MUL, 01 MAC, 10 MSUB, 11 CHAIN.
- chainin  in  2W  addend for CHAIN, captured with the operands.
- result  out  2W  accumulator / result register.
- out_valid  out  1  result updated this cycle by a retiring op.
- ovf  out  1  overflow flag of the op that last retired.

## Operation
- Input stage captures dataa_0, datab_0, signa, signb, op, chainin and in_valid on every clock0 edge with ena0=1.
- Product p: each operand is extended to W+1 bits, sign-extended if its sign bit is set, zero-extended otherwise. The (W+1)×(W+1) product is truncated to 2W bits, which is exact for all sign combinations. p is computed over STAGES-1 further register stages, carrying the valid, op, and sign bits alongside.
- Final stage (the result register is the accumulator) acts as follows when the valid bit of that stage is set:
  - MUL: result ← p; ovf ← 0.
  - MAC: result ← result + p.
  - MSUB: result ← result − p.
  - CHAIN: result ← chainin(captured) + p.
- Add/subtract is 2W bits wide. Overflow rule: signed overflow if signa|signb of that op, otherwise unsigned carry (MAC/CHAIN) or borrow (MSUB). ovf is set per op, not sticky.
- Bubble (valid bit 0) at the final stage: result and ovf hold, out_valid ← 0.
- Back-to-back MAC ops accumulate in issue order with no hazard; the accumulator feedback is single-cycle.
- sclr0=1 overrides ena0 and clears the following: result=0, ovf=0, out_valid=0, all pipeline valid bits=0. Ops in flight are discarded. Datapath registers other than valid bits need not be cleared.

## Timing
- Latency L = STAGES+1 enabled edges from input capture to result/out_valid. For STAGES=2, an op presented before edge n appears after edge n+3 counting the capture edge as n+1, i.e. result is visible in cycle n+3.
- Throughput is one op per enabled cycle.
- ena0=0 for k cycles delays every in-flight op by exactly k cycles. out_valid holds its value while stalled, so a stalled retirement stays visible. in_valid is ignored while ena0=0.
- sclr0 asserted mid-stream: outputs are 0 on the cycle after the edge. The first op accepted after sclr0 deasserts retires L cycles later.
- Reset values: result 0, out_valid 0, ovf 0.

## Configuration
- DSP_MAC_SAT_EN defined: on overflow in MAC/MSUB/CHAIN, result clamps instead of wrapping. Signed ops clamp to 0x7FF..F (positive overflow) or 0x800..0 (negative). Unsigned ops clamp to all-ones on carry or 0 on borrow. ovf is still set.
- Not defined: result wraps modulo 2^(2W); ovf is still reported. No saturation logic is synthesised.

## Test plan
- W=32, STAGES=2, MUL unsigned 0xFFFFFFFF×0xFFFFFFFF -> result 0xFFFFFFFE00000001 with out_valid pulse exactly 3 cycles after issue, ovf 0. Same operands with signa=signb=1 -> result 0x0000000000000001.
- MUL 3×4, then MAC 5×6, MSUB 2×2 back-to-back -> results 12, 42, 38 on consecutive cycles.
- CHAIN with chainin=0x10, 7×(−2) (signb=1) -> result 0x0000000000000002. Repeat with an in_valid=0 bubble between ops -> result holds and out_valid is 0 in the bubble cycle.
- Signed MAC with result=0x7FFFFFFFFFFFFFFF, 1×1 -> ovf=1 and result 0x8000000000000000 without the macro, 0x7FFFFFFFFFFFFFFF with DSP_MAC_SAT_EN. Unsigned MSUB 0−1 -> ovf=1, result all-ones wrapped, or 0 saturated.
- Issue MUL 9×9, drop ena0 for 4 cycles one cycle after issue -> result 81 appears exactly 7 cycles after issue, and no out_valid occurs during the stall.
- Three MACs in flight, assert sclr0 one cycle -> result 0, out_valid 0 for the next 3 cycles. A new MUL 2×2 afterwards -> 4 after L cycles.
